// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame constants and common commands.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    // Data bits per frame, and the device falling edge that clocks out the stop bit.
    localparam logic [3:0] PS2_NBITS = 4'd8;
    localparam logic [3:0] LAST_FALL = 4'd10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser plus falling-edge detector for one PS/2 bus line.
module ps2_sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Synchroniser chain and history flop; all reset high because an idle bus floats high.
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, serialise one byte, check ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    output logic       TX_READY,
    output logic       BUSY,
    output logic       TX_DONE,
    output logic       TX_ERR,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic             ok_q, ok_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic clk_lvl, clk_fall;
    logic data_lvl, data_fall_unused;
    logic start_ok, watched, progress;

    ps2_sync_edge u_clk_sync (
        .CLK   (CLK),
        .RST   (RST),
        .line  (PS2_CLK_IN),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .CLK   (CLK),
        .RST   (RST),
        .line  (PS2_DATA_IN),
        .level (data_lvl),
        .fall  (data_fall_unused)
    );

    assign start_ok = TX_START & TX_READY;
    // The watchdog runs only while waiting on the device; any device activity restarts it.
    assign watched  = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);
    assign progress = clk_fall || ((state_q == WAIT_IDLE) && clk_lvl && data_lvl);

    // Next-state, bus-drive and completion logic.
    // NOTE: every signal gets a default first so no latch is inferred on untaken paths.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parity_d  = parity_q;
        ok_d      = ok_q;
        bit_idx_d = bit_idx_q;
        inh_d     = '0;
        tmo_d     = '0;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (watched) begin
            tmo_d = clk_fall ? '0 : tmo_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (start_ok) begin
                    data_d   = TX_DATA;
                    parity_d = odd_parity(TX_DATA);
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = RTS;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            RTS: begin
                // Release the clock with data still low: this is the start bit.
                clk_oe_d  = 1'b0;
                bit_idx_d = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (clk_fall) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q < PS2_NBITS) begin
                        data_oe_d = ~data_q[bit_idx_q[2:0]];
                    end else if (bit_idx_q == PS2_NBITS) begin
                        data_oe_d = ~parity_q;
                    end else if (bit_idx_q == LAST_FALL - 4'd1) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ok_d    = ~data_lvl;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_lvl && data_lvl) begin
                    done_d  = ok_q;
                    err_d   = ~ok_q;
                    tmo_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (watched && !progress && (tmo_q == TMO_LAST)) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
            tmo_d     = '0;
            state_d   = IDLE;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            data_q    <= '0;
            parity_q  <= 1'b0;
            ok_q      <= 1'b0;
            bit_idx_q <= '0;
            inh_q     <= '0;
            tmo_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            ok_q      <= ok_d;
            bit_idx_q <= bit_idx_d;
            inh_q     <= inh_d;
            tmo_q     <= tmo_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Ready is withheld during the completion pulse so a new request starts one cycle later.
    assign TX_READY    = (state_q == IDLE) && !done_q && !err_q;
    assign BUSY        = (state_q != IDLE);
    assign TX_DONE     = done_q;
    assign TX_ERR      = err_q;
    assign PS2_CLK_OE  = clk_oe_q;
    assign PS2_DATA_OE = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device on an open-drain bus.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 10;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_START = 1'b0;
    logic       TX_READY, BUSY, TX_DONE, TX_ERR;
    logic       PS2_CLK_OE, PS2_DATA_OE;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       bus_clk, bus_data;

    // Open-drain bus: a line is high only when neither side pulls it low.
    assign bus_clk  = dev_clk & ~PS2_CLK_OE;
    assign bus_data = dev_data & ~PS2_DATA_OE;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .TX_DATA     (TX_DATA),
        .TX_START    (TX_START),
        .TX_READY    (TX_READY),
        .BUSY        (BUSY),
        .TX_DONE     (TX_DONE),
        .TX_ERR      (TX_ERR),
        .PS2_CLK_IN  (bus_clk),
        .PS2_DATA_IN (bus_data),
        .PS2_CLK_OE  (PS2_CLK_OE),
        .PS2_DATA_OE (PS2_DATA_OE)
    );

    always #5 CLK = ~CLK;

    typedef enum int {K_INH, K_BIT, K_DONE, K_ERR} kind_t;
    typedef struct {
        kind_t kind;
        int    val;
    } item_t;

    item_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    dev_falls = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic expect_item(input kind_t k, input logic [31:0] act, input string name);
        item_t it;
        check({name, "_expected"}, 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            check({name, "_kind"}, it.kind, k);
            check(name, act, it.val);
        end
    endtask

    // frame[0] is the start bit, then d0..d7, parity, stop: the order the device sees them.
    task automatic push_frame(input logic [10:0] frame, input int nbits,
                              input bit has_res, input kind_t res);
        exp_q.push_back('{K_INH, INH});
        for (int i = 0; i < nbits; i++) exp_q.push_back('{K_BIT, int'(frame[i])});
        if (has_res) exp_q.push_back('{res, 1});
    endtask

    // Device model: waits for request-to-send, then issues n clock pulses; ACKs on pulse 11.
    task automatic dev_frame(input int n, input bit ack);
        int w = 0;
        while (!(bus_clk && !bus_data) && w < 300) begin
            @(negedge CLK);
            w++;
        end
        check("dev_rts_seen", 32'(w < 300), 1);
        if (w < 300) begin
            repeat (HALF) @(negedge CLK);
            for (int i = 1; i <= n; i++) begin
                if (i == 11 && ack) dev_data = 1'b0;
                dev_clk = 1'b0;
                dev_falls++;
                repeat (HALF) @(negedge CLK);
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                repeat (HALF) @(negedge CLK);
            end
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        int w = 0;
        while (!TX_READY && w < 100) begin
            @(negedge CLK);
            w++;
        end
        @(negedge CLK);
        TX_DATA  = d;
        TX_START = 1'b1;
        @(negedge CLK);
        TX_START = 1'b0;
        check("busy_after_start", BUSY, 1);
        check("ready_after_start", TX_READY, 0);
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!TX_READY && w < 3000) begin
            @(negedge CLK);
            w++;
        end
        check("xfer_complete", 32'(TX_READY), 1);
        check("busy_clear", BUSY, 0);
    endtask

    task automatic wait_falls(input int n);
        int w = 0;
        while (dev_falls < n && w < 2000) begin
            @(negedge CLK);
            w++;
        end
        check("dev_falls_reached", 32'(dev_falls >= n), 1);
    endtask

    // Monitor: pops the scoreboard whenever the bus or the status pulses present something.
    initial begin : monitor
        int   pos;
        int   inh_cnt;
        logic dev_clk_prev;
        pos = 0;
        inh_cnt = 0;
        dev_clk_prev = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (RST) begin
                pos = 0;
                inh_cnt = 0;
            end else begin
                if (PS2_CLK_OE && !PS2_DATA_OE) begin
                    inh_cnt++;
                end else begin
                    if (PS2_CLK_OE && PS2_DATA_OE && inh_cnt > 0)
                        expect_item(K_INH, inh_cnt, "inhibit_len");
                    inh_cnt = 0;
                end
                if (dev_clk_prev && !dev_clk && pos == 0) begin
                    expect_item(K_BIT, bus_data, "start_bit");
                    pos = 1;
                end else if (!dev_clk_prev && dev_clk && pos > 0) begin
                    if (pos <= 10) expect_item(K_BIT, bus_data, $sformatf("frame_bit%0d", pos));
                    pos = (pos == 11) ? 0 : pos + 1;
                end
                if (TX_DONE || TX_ERR) begin
                    check("done_err_exclusive", TX_DONE & TX_ERR, 0);
                    if (TX_DONE) expect_item(K_DONE, TX_DONE, "tx_done");
                    if (TX_ERR) expect_item(K_ERR, TX_ERR, "tx_err");
                end
            end
            dev_clk_prev = dev_clk;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [10:0] frame;
        int          w;
        int          edges;

        // Reset and idle.
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check("rst_ready", TX_READY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_clk_oe", PS2_CLK_OE, 0);
        check("rst_data_oe", PS2_DATA_OE, 0);
        check("rst_done", TX_DONE, 0);
        check("rst_err", TX_ERR, 0);

        // 0xED with device ACK: {stop, parity, data, start}.
        frame = 11'b1_1_11101101_0;
        push_frame(frame, 11, 1'b1, K_DONE);
        dev_falls = 0;
        fork
            dev_frame(11, 1'b1);
            begin
                start_tx(CMD_SET_LEDS);
                wait_ready();
            end
        join

        // 0xF4 with the device leaving data high at ACK time.
        frame = 11'b1_0_11110100_0;
        push_frame(frame, 11, 1'b1, K_ERR);
        dev_falls = 0;
        fork
            dev_frame(11, 1'b0);
            begin
                start_tx(CMD_ENABLE);
                wait_ready();
            end
        join

        // Silent device: timeout measured from the request-to-send cycle.
        exp_q.push_back('{K_INH, INH});
        exp_q.push_back('{K_ERR, 1});
        start_tx(CMD_ENABLE);
        w = 0;
        while (!(PS2_CLK_OE && PS2_DATA_OE) && w < 100) begin
            @(negedge CLK);
            w++;
        end
        check("rts_seen", 32'(PS2_CLK_OE && PS2_DATA_OE), 1);
        edges = 0;
        while (edges < TMO + 50) begin
            @(posedge CLK);
            #1;
            edges++;
            if (TX_ERR) break;
        end
        // First edge counted enters SEND; the error lands TMO edges after that.
        check("timeout_latency", edges, TMO + 1);
        check("timeout_clk_oe", PS2_CLK_OE, 0);
        check("timeout_data_oe", PS2_DATA_OE, 0);
        @(posedge CLK);
        #1;
        check("timeout_ready_next", TX_READY, 1);
        check("timeout_err_one_cycle", TX_ERR, 0);

        // New request mid-transfer must be ignored.
        frame = 11'b1_1_11101101_0;
        push_frame(frame, 11, 1'b1, K_DONE);
        dev_falls = 0;
        fork
            dev_frame(11, 1'b1);
            begin
                start_tx(CMD_SET_LEDS);
                wait_falls(3);
                @(negedge CLK);
                check("ready_mid_xfer", TX_READY, 0);
                TX_DATA  = 8'h00;
                TX_START = 1'b1;
                @(negedge CLK);
                TX_START = 1'b0;
                wait_ready();
            end
        join

        // Reset after fall 5 of 0xA5: only start plus d0..d3 reach the device.
        frame = 11'b1_1_10100101_0;
        push_frame(frame, 5, 1'b0, K_DONE);
        dev_falls = 0;
        fork
            dev_frame(5, 1'b0);
            begin
                start_tx(8'hA5);
                wait_falls(5);
                repeat (4) @(negedge CLK);
                RST = 1'b1;
                @(negedge CLK);
                check("midrst_clk_oe", PS2_CLK_OE, 0);
                check("midrst_data_oe", PS2_DATA_OE, 0);
                check("midrst_busy", BUSY, 0);
                check("midrst_ready", TX_READY, 1);
                check("midrst_done", TX_DONE, 0);
                check("midrst_err", TX_ERR, 0);
                RST = 1'b0;
            end
        join

        repeat (60) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
